ram_clr: RTL and testbench
==========================

Name: ram_clr

Overview:
- Parametrised single-port data RAM with selectable read latency and a built-in clear engine.
- The clear engine sweeps every word to INIT_VAL after reset, or on request.
- Drop-in successor to the fixed 16-bit ram8 … ram16k family; the CPU data memory instantiates it.
- busy tells the memory-mapping logic when the array cannot be accessed.

Parameters:
- WIDTH, 16: data word width in bits.
- DEPTH, 16384: number of words; must satisfy 2 <= DEPTH <= 2**ADDR_W.
- ADDR_W, 14: address width.
- CLEAR_ON_RESET, 1: 1 = run the clear sweep after reset; 0 = go straight to IDLE, leaving contents unchanged (X in simulation after power-up).
- REG_OUT, 0: 0 = combinational read; 1 = registered read with 1-cycle latency.
- INIT_VAL, 0: WIDTH-bit value written by the sweep and returned while busy or out of range.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  WIDTH  write data.
- addr  input  ADDR_W  read/write address.
- load  input  1  write enable: mem[addr] <= in at the rising edge.
- clear  input  1  single-cycle request to start a clear sweep.
- out  output  WIDTH  read data.
- busy  output  1  high while a clear sweep is in progress.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- States: IDLE and CLEAR. Internal sweep pointer ptr is ADDR_W bits wide.
- On an edge with reset=1:
  - CLEAR_ON_RESET=1: state <= CLEAR, ptr <= 0.
  - CLEAR_ON_RESET=0: state <= IDLE.
  - Registered out (REG_OUT=1) <= INIT_VAL.
  - No array write happens on a reset edge.
- Reset has priority over everything. Reset asserted mid-sweep restarts the sweep from ptr=0.
- busy is registered and equals (state==CLEAR).
  - After reset deasserts with CLEAR_ON_RESET=1, busy stays high for exactly DEPTH rising edges, then drops.
- CLEAR state, each edge:
  - mem[ptr] <= INIT_VAL, then ptr <= ptr+1.
  - On the edge that writes ptr==DEPTH-1, state <= IDLE and ptr <= 0.
  - The full sweep is exactly DEPTH edges.
- IDLE with clear=1: state <= CLEAR, ptr <= 0 on that edge. A load in the same cycle is dropped (clear wins).
- clear while already in CLEAR is ignored; the sweep is not restarted or extended.
- load while busy is ignored; the array is not modified except by the sweep.
- Write in IDLE: when load=1 and addr < DEPTH, mem[addr] <= in at the edge.
  - addr >= DEPTH (non-power-of-2 DEPTH): the write is discarded and no other word is aliased.
- Read, REG_OUT=0:
  - out = mem[addr] combinationally.
  - out = INIT_VAL while busy=1 or when addr >= DEPTH.
  - A same-cycle write shows the new value only after the edge.
- Read, REG_OUT=1:
  - At each non-reset edge, out <= (busy or addr >= DEPTH) ? INIT_VAL : mem[addr].
  - Read-before-write: a load to the same address on the same edge returns the OLD data; the new data appears on the following edge.
- Width rules:
  - in/out are exactly WIDTH bits, with no sign extension.
  - ptr compares against DEPTH-1 at ADDR_W width, so there is no wrap beyond DEPTH.
- No X on out after the first sweep completes, for any in-range address.

Test Plan:
1. WIDTH=16, DEPTH=8, ADDR_W=3, CLEAR_ON_RESET=1, REG_OUT=0.
   - Stimulus: reset high for 2 cycles, then low, with load=1 throughout the sweep.
   - Required: busy=1 for exactly 8 edges then 0; out=0x0000 while busy; afterwards mem[0..7] all read 0x0000 and the loads during the sweep had no effect.
2. Same config, IDLE.
   - Stimulus: write 0x1234 to addr 5, then read addr 5.
   - Required: out=0x1234 combinationally in the cycle after the write edge. addr 4 still reads 0x0000.
3. REG_OUT=1.
   - Stimulus: mem[2]=0xAAAA, then load 0x5555 to addr 2 with the read on the same edge.
   - Required: out=0xAAAA after that edge; out=0x5555 after the next edge.
4. DEPTH=6, ADDR_W=3.
   - Stimulus: write 0xBEEF to addr 6 and to addr 7.
   - Required: out=0x0000 at both addresses; mem[0..5] unchanged.
5. Clear and reset corner cases.
   - Stimulus: pulse clear together with load(addr 1, 0x7777) in IDLE; pulse clear again at sweep edge 3; assert reset at sweep edge 5.
   - Required: the load is dropped; the second clear is ignored; the sweep restarts from ptr=0 and busy stays high 8 more edges after reset deasserts.
6. CLEAR_ON_RESET=0, INIT_VAL=0xFFFF.
   - Stimulus: reset.
   - Required: busy=0 immediately. A later clear pulse gives busy high for 8 edges, then all words read 0xFFFF.

Source files
------------

// File: rtl/ram_clr.sv
// Single-port data RAM with selectable read latency and a clear engine that
// sweeps every word to INIT_VAL after reset or on a clear request.
module ram_clr #(
  parameter int                WIDTH          = 16,
  parameter int                DEPTH          = 16384,
  parameter int                ADDR_W         = 14,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter bit                REG_OUT        = 1'b0,
  parameter logic [WIDTH-1:0]  INIT_VAL       = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [WIDTH-1:0]  mem_wd;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  mem [DEPTH];

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign busy     = (state == ST_CLEAR);

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    mem_we     = 1'b0;
    mem_wa     = addr;
    mem_wd     = in;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          state_next = ST_CLEAR;
          ptr_next   = '0;
        end else if (load && in_range) begin
          mem_we = 1'b1;
        end
      end
      ST_CLEAR: begin
        mem_we = 1'b1;
        mem_wa = ptr;
        mem_wd = INIT_VAL;
        if (ptr == LAST_PTR) begin
          state_next = ST_IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // NOTE: the array has no reset; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign rd_data = (busy || !in_range) ? INIT_VAL : mem[addr];

  generate
    if (REG_OUT) begin : g_reg_out
      logic [WIDTH-1:0] out_q;
      // Samples pre-edge contents, so a same-edge write returns the old word.
      always_ff @(posedge clk) begin
        if (reset) begin
          out_q <= INIT_VAL;
        end else begin
          out_q <= rd_data;
        end
      end
      assign out = out_q;
    end else begin : g_comb_out
      assign out = rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_ram_clr.sv
// Scoreboard bench for ram_clr: four configurations share one clock; stimulus
// pushes expectations, a negedge monitor pops and compares them.
module tb_ram_clr;

  typedef enum int {S_A_OUT, S_A_BUSY, S_B_OUT, S_C_OUT, S_D_OUT, S_D_BUSY} sel_t;
  typedef struct {
    sel_t        sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (DEPTH 8, combinational read) has private inputs.
  logic        rst_a, load_a, clr_a;
  logic [15:0] in_a;
  logic [2:0]  addr_a;
  logic [15:0] out_a;
  logic        busy_a;
  // Instances B, C, D share one set of inputs.
  logic        rst_x, load_x, clr_x;
  logic [15:0] in_x;
  logic [2:0]  addr_x;
  logic [15:0] out_b, out_c, out_d;
  logic        busy_b, busy_c, busy_d;

  ram_clr #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .CLEAR_ON_RESET(1'b1), .REG_OUT(1'b0),
            .INIT_VAL(16'h0000)) u_a (
    .clk(clk), .reset(rst_a), .in(in_a), .addr(addr_a), .load(load_a),
    .clear(clr_a), .out(out_a), .busy(busy_a));

  ram_clr #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .CLEAR_ON_RESET(1'b1), .REG_OUT(1'b1),
            .INIT_VAL(16'h0000)) u_b (
    .clk(clk), .reset(rst_x), .in(in_x), .addr(addr_x), .load(load_x),
    .clear(clr_x), .out(out_b), .busy(busy_b));

  ram_clr #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .CLEAR_ON_RESET(1'b1), .REG_OUT(1'b0),
            .INIT_VAL(16'h0000)) u_c (
    .clk(clk), .reset(rst_x), .in(in_x), .addr(addr_x), .load(load_x),
    .clear(clr_x), .out(out_c), .busy(busy_c));

  ram_clr #(.WIDTH(16), .DEPTH(8), .ADDR_W(3), .CLEAR_ON_RESET(1'b0), .REG_OUT(1'b0),
            .INIT_VAL(16'hFFFF)) u_d (
    .clk(clk), .reset(rst_x), .in(in_x), .addr(addr_x), .load(load_x),
    .clear(clr_x), .out(out_d), .busy(busy_d));

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes every pending expectation while outputs are stable.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = sb.pop_front();
      case (e.sel)
        S_A_OUT:  act = out_a;
        S_A_BUSY: act = {15'd0, busy_a};
        S_B_OUT:  act = out_b;
        S_C_OUT:  act = out_c;
        S_D_OUT:  act = out_d;
        default:  act = {15'd0, busy_d};
      endcase
      check(e.name, act, e.exp);
    end
  end

  task automatic expect_val(input sel_t sel, input logic [15:0] exp, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; load_a = 1'b0; clr_a = 1'b0; in_a = '0; addr_a = '0;
    rst_x = 1'b1; load_x = 1'b0; clr_x = 1'b0; in_x = '0; addr_x = '0;
    step();
    step();
    rst_a = 1'b0;
    rst_x = 1'b0;

    // 1: sweep after reset, loads attempted throughout are ignored
    expect_val(S_D_BUSY, 16'd0, "d_busy_after_reset");
    load_a = 1'b1;
    in_a   = 16'hDEAD;
    for (int i = 0; i < 8; i++) begin
      addr_a = 3'(i);
      expect_val(S_A_BUSY, 16'd1, $sformatf("a_busy_sweep_%0d", i));
      expect_val(S_A_OUT, 16'h0000, $sformatf("a_out_busy_%0d", i));
      step();
    end
    load_a = 1'b0;
    expect_val(S_A_BUSY, 16'd0, "a_busy_done");
    for (int i = 0; i < 8; i++) begin
      addr_a = 3'(i);
      expect_val(S_A_OUT, 16'h0000, $sformatf("a_cleared_%0d", i));
      step();
    end

    // 2: write then combinational read
    addr_a = 3'd5; in_a = 16'h1234; load_a = 1'b1;
    expect_val(S_A_OUT, 16'h0000, "a_pre_write_edge");
    step();
    load_a = 1'b0;
    expect_val(S_A_OUT, 16'h1234, "a_read5");
    step();
    addr_a = 3'd4;
    expect_val(S_A_OUT, 16'h0000, "a_read4");
    step();

    // 3: registered read-before-write on B
    addr_x = 3'd2; in_x = 16'hAAAA; load_x = 1'b1;
    step();
    expect_val(S_B_OUT, 16'h0000, "b_old_before_first_write");
    in_x = 16'h5555;
    step();
    load_x = 1'b0;
    expect_val(S_B_OUT, 16'hAAAA, "b_read_before_write");
    step();
    expect_val(S_B_OUT, 16'h5555, "b_new_data");
    step();

    // 4: out-of-range writes on C (DEPTH 6)
    addr_x = 3'd6; in_x = 16'hBEEF; load_x = 1'b1;
    step();
    addr_x = 3'd7;
    step();
    load_x = 1'b0;
    addr_x = 3'd6;
    expect_val(S_C_OUT, 16'h0000, "c_read6");
    step();
    addr_x = 3'd7;
    expect_val(S_C_OUT, 16'h0000, "c_read7");
    step();
    for (int i = 0; i < 6; i++) begin
      addr_x = 3'(i);
      expect_val(S_C_OUT, (i == 2) ? 16'h5555 : 16'h0000, $sformatf("c_mem_%0d", i));
      step();
    end

    // 5a: clear with a simultaneous load; a second clear mid-sweep is ignored
    addr_a = 3'd1; in_a = 16'h7777; load_a = 1'b1; clr_a = 1'b1;
    step();
    load_a = 1'b0; clr_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      clr_a = (i == 2);
      expect_val(S_A_BUSY, 16'd1, $sformatf("a_busy_clr_%0d", i));
      step();
    end
    clr_a = 1'b0;
    expect_val(S_A_BUSY, 16'd0, "a_busy_clr_done");
    expect_val(S_A_OUT, 16'h0000, "a_load_dropped");
    step();
    addr_a = 3'd5;
    expect_val(S_A_OUT, 16'h0000, "a_swept5");
    step();

    // 5b: reset at sweep edge 5 restarts a full sweep
    clr_a = 1'b1;
    step();
    clr_a = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_val(S_A_BUSY, 16'd1, $sformatf("a_busy_rst_%0d", i));
      step();
    end
    expect_val(S_A_BUSY, 16'd0, "a_busy_rst_done");
    step();

    // 6: clear on D (no clear on reset, INIT_VAL 0xFFFF)
    clr_x = 1'b1;
    step();
    clr_x = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_val(S_D_BUSY, 16'd1, $sformatf("d_busy_%0d", i));
      expect_val(S_D_OUT, 16'hFFFF, $sformatf("d_out_busy_%0d", i));
      step();
    end
    expect_val(S_D_BUSY, 16'd0, "d_busy_done");
    for (int i = 0; i < 8; i++) begin
      addr_x = 3'(i);
      expect_val(S_D_OUT, 16'hFFFF, $sformatf("d_mem_%0d", i));
      step();
    end

    step();
    if (sb.size() != 0) begin
      bad++;
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
